key_scheduler: RTL

KEY_SCHEDULER -- requirements
Module: key_scheduler

---
 rtl/key_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/key_scheduler.sv
// Keyboard scheduler: time-shares the tone path among held keys and emits
// press/release event records to a downstream FIFO with a current scale tag.
module key_scheduler #(
    parameter int N_KEYS       = 13,
    parameter int DWELL_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys,
    input  logic              oct_up,
    input  logic              oct_dn,
    output logic [3:0]        note_idx,
    output logic              note_valid,
    output logic [2:0]        scale,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [9:0]        ev_data,
    output logic [7:0]        drop_cnt
);

    localparam int                CW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [4:0]        TOP_KEY    = 5'(N_KEYS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        last_idx_r;
    logic [CW-1:0]     dwell_cnt_r;
    logic [N_KEYS-1:0] keys_q_r;
    logic [N_KEYS-1:0] pend_p_r;
    logic [N_KEYS-1:0] pend_r_r;

    logic [N_KEYS-1:0] rise_s;
    logic [N_KEYS-1:0] fall_s;
    logic [4:0]        grant_s;
    logic [4:0]        sel_p_s;
    logic [4:0]        sel_r_s;
    logic              load_s;
    logic [N_KEYS-1:0] clr_p_s;
    logic [N_KEYS-1:0] clr_r_s;
    logic [N_KEYS-1:0] merge_p_s;
    logic [N_KEYS-1:0] merge_r_s;
    logic [8:0]        drop_sum_s;
    logic [7:0]        drop_next_s;
    logic [9:0]        ev_word_s;
    logic [2:0]        scale_next_s;

    // Round-robin search: first held key after 'last', wrapping, 'last' itself checked last.
    function automatic logic [4:0] next_key(input logic [N_KEYS-1:0] held, input logic [3:0] last);
        logic [4:0] res;
        logic [4:0] idx;
        res = 5'd0;
        idx = {1'b0, last};
        for (int i = 0; i < N_KEYS; i++) begin
            if (idx == TOP_KEY) idx = 5'd0;
            else                idx = idx + 5'd1;
            if (!res[4] && held[idx[3:0]]) res = {1'b1, idx[3:0]};
            else                           res = res;
        end
        return res;
    endfunction

    // Returns {found, index} of the lowest set bit.
    function automatic logic [4:0] lowest_set(input logic [N_KEYS-1:0] v);
        logic [4:0] res;
        res = 5'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 4'(i)};
            else      res = res;
        end
        return res;
    endfunction

    function automatic logic [4:0] popcount(input logic [N_KEYS-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < N_KEYS; i++) n = n + {4'd0, v[i]};
        return n;
    endfunction

    // Edge detection, emitter selection, merge accounting and scale stepping.
    always_comb begin
        rise_s  = keys & ~keys_q_r;
        fall_s  = ~keys & keys_q_r;
        grant_s = next_key(keys, last_idx_r);
        sel_p_s = lowest_set(pend_p_r);
        sel_r_s = lowest_set(pend_r_r);
        load_s  = !ev_valid && (sel_p_s[4] || sel_r_s[4]);
        clr_p_s = '0;
        clr_r_s = '0;
        if (load_s && sel_p_s[4]) begin
            clr_p_s   = 13'b1 << sel_p_s[3:0];
            ev_word_s = {1'b1, scale, sel_p_s[3:0], 2'b00};
        end else if (load_s) begin
            clr_r_s   = 13'b1 << sel_r_s[3:0];
            ev_word_s = {1'b0, scale, sel_r_s[3:0], 2'b00};
        end else begin
            ev_word_s = ev_data;
        end
        merge_p_s  = rise_s & pend_p_r & ~clr_p_s;
        merge_r_s  = fall_s & pend_r_r & ~clr_r_s;
        drop_sum_s = {1'b0, drop_cnt} + {4'd0, popcount(merge_p_s)} + {4'd0, popcount(merge_r_s)};
        if (drop_sum_s > 9'd255) drop_next_s = 8'd255;
        else                     drop_next_s = drop_sum_s[7:0];
        if (oct_up && !oct_dn && scale < 3'd5)      scale_next_s = scale + 3'd1;
        else if (oct_dn && !oct_up && scale > 3'd1) scale_next_s = scale - 3'd1;
        else                                        scale_next_s = scale;
    end

    // Event path: key sampling, pending flags, drop counter, scale and the output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q_r <= '0;
            pend_p_r <= '0;
            pend_r_r <= '0;
            drop_cnt <= 8'd0;
            scale    <= 3'd1;
            ev_valid <= 1'b0;
            ev_data  <= 10'd0;
        end else begin
            keys_q_r <= keys;
            pend_p_r <= (pend_p_r & ~clr_p_s) | rise_s;
            pend_r_r <= (pend_r_r & ~clr_r_s) | fall_s;
            drop_cnt <= drop_next_s;
            scale    <= scale_next_s;
            ev_data  <= ev_word_s;
            if (ev_valid) begin
                ev_valid <= !ev_ready;
            end else begin
                ev_valid <= load_s;
            end
        end
    end

    // Tone-path scheduler: one SCAN cycle between dwells, note_valid high only in DWELL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            note_idx    <= 4'd0;
            note_valid  <= 1'b0;
            last_idx_r  <= 4'(N_KEYS - 1);
            dwell_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    note_valid <= 1'b0;
                    if (|keys) state_r <= SCAN;
                    else       state_r <= IDLE;
                end
                SCAN: begin
                    if (grant_s[4]) begin
                        note_idx    <= grant_s[3:0];
                        last_idx_r  <= grant_s[3:0];
                        dwell_cnt_r <= '0;
                        note_valid  <= 1'b1;
                        state_r     <= DWELL;
                    end else begin
                        note_valid  <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_r == DWELL_LAST || !keys[note_idx]) begin
                        note_valid <= 1'b0;
                        state_r    <= SCAN;
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    note_valid <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
